flash_loader: RTL and testbench

- Boot-time copier sitting directly upstream of the serial flash controller.
- Drives the controller's memory-access side (enable, read, start address) and consumes its word stream (data plus word-ready pulse).
- Writes NUM_WORDS consecutive words from flash into a parallel RAM port (program/data memory) and signals done or error.
- Instantiated between the flash controller and the on-chip RAM preload path.

---
 rtl/flash_loader.sv | 160 ++++++++++++++++
 tb/tb_flash_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_loader.sv
// flash_loader: boot-time copier from the serial flash controller word stream into a parallel RAM port.
// Optional checksum verification of the copied image is enabled by defining FLASH_LOADER_CHECKSUM_EN.
`default_nettype none

module flash_loader #(
    parameter int WORD_BITS      = 8,
    parameter int ADDRESS_WORDS  = 2,
    parameter int MEM_ADDR_BITS  = 12,
    parameter int NUM_WORDS      = 256,
    parameter int FLASH_START    = 0,
    parameter int MEM_START      = 0,
    parameter int AUTO_START     = 1,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                                in_clk,
    input  logic                                in_rst,
    input  logic                                in_start,
    output logic                                out_busy,
    output logic                                out_done,
    output logic                                out_error,
    output logic                                out_flash_enable,
    output logic                                out_flash_read,
    output logic [WORD_BITS*ADDRESS_WORDS-1:0]  out_flash_addr,
    input  logic [WORD_BITS-1:0]                in_flash_data,
    input  logic                                in_flash_word_ready,
`ifdef FLASH_LOADER_CHECKSUM_EN
    input  logic [WORD_BITS-1:0]                in_expected_checksum,
    output logic [WORD_BITS-1:0]                out_checksum,
`endif
    output logic [MEM_ADDR_BITS-1:0]            out_mem_addr,
    output logic [WORD_BITS-1:0]                out_mem_data,
    output logic                                out_mem_write,
    output logic [MEM_ADDR_BITS:0]              out_words_loaded
);

    localparam int FA_BITS = WORD_BITS * ADDRESS_WORDS;
    localparam int TO_BITS = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FA_BITS-1:0]       FLASH_ADDR = FA_BITS'(FLASH_START);
    localparam logic [MEM_ADDR_BITS-1:0] MEM_BASE   = MEM_ADDR_BITS'(MEM_START);
    localparam logic [MEM_ADDR_BITS:0]   NUM_TOTAL  = (MEM_ADDR_BITS + 1)'(NUM_WORDS);
    localparam logic [TO_BITS-1:0]       TO_LAST    = TO_BITS'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic                     first_q;
    logic [MEM_ADDR_BITS:0]   count_q, count_d;
    logic [TO_BITS-1:0]       timeout_q, timeout_d;
    logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_BITS-1:0]     mem_data_q, mem_data_d;
    logic                     write_q, write_d;
    logic [WORD_BITS-1:0]     sum_q, sum_d;
    logic                     sum_ok;
    logic                     start_load;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q    <= S_IDLE;
            first_q    <= 1'b1;
            count_q    <= '0;
            timeout_q  <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            write_q    <= 1'b0;
            sum_q      <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= 1'b0;
            count_q    <= count_d;
            timeout_q  <= timeout_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            write_q    <= write_d;
            sum_q      <= sum_d;
        end
    end

`ifdef FLASH_LOADER_CHECKSUM_EN
    assign sum_ok       = ((sum_q + in_flash_data) == in_expected_checksum);
    assign out_checksum = sum_q;
`else
    assign sum_ok       = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        timeout_d  = timeout_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        write_d    = 1'b0;
        sum_d      = sum_q;
        start_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_start || ((AUTO_START != 0) && first_q)) begin
                    start_load = 1'b1;
                end
            end
            S_DONE, S_ERROR: begin
                if (in_start) begin
                    start_load = 1'b1;
                end
            end
            S_READ: begin
                // A ready pulse takes priority over timeout expiry in the same cycle.
                if (in_flash_word_ready) begin
                    mem_data_d = in_flash_data;
                    mem_addr_d = MEM_BASE + count_q[MEM_ADDR_BITS-1:0];
                    write_d    = 1'b1;
                    count_d    = count_q + 1'b1;
                    timeout_d  = '0;
                    sum_d      = sum_q + in_flash_data;
                    if (count_d == NUM_TOTAL) begin
                        state_d = sum_ok ? S_DONE : S_ERROR;
                    end
                end else if (timeout_q == TO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start_load) begin
            if (NUM_WORDS == 0) begin
                state_d = S_DONE;
            end else begin
                state_d   = S_READ;
                count_d   = '0;
                timeout_d = '0;
                sum_d     = '0;
            end
        end
    end

    assign out_busy         = (state_q == S_READ);
    assign out_flash_enable = (state_q == S_READ);
    assign out_done         = (state_q == S_DONE);
    assign out_error        = (state_q == S_ERROR);
    assign out_flash_read   = 1'b1;
    assign out_flash_addr   = FLASH_ADDR;
    assign out_mem_addr     = mem_addr_q;
    assign out_mem_data     = mem_data_q;
    assign out_mem_write    = write_q;
    assign out_words_loaded = count_q;

endmodule

`default_nettype wire

// File: tb/tb_flash_loader.sv
// tb_flash_loader: directed self-checking bench for flash_loader.
`default_nettype none

module tb_flash_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, ready;
    logic [7:0]  data;
    logic        busy, done, error, en, rd, wr;
    logic [15:0] faddr;
    logic [11:0] maddr;
    logic [7:0]  mdata;
    logic [12:0] words;

    logic        start0;
    logic        busy0, done0, error0, en0, rd0, wr0;
    logic [15:0] faddr0;
    logic [11:0] maddr0;
    logic [7:0]  mdata0;
    logic [12:0] words0;
    logic        seen_en0 = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  wd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [11:0] wa [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [7:0]  ck, ck0, ckc, expc;
    logic        startc, readyc;
    logic [7:0]  datac;
    logic        busyc, donec, errorc, enc, rdc, wrc;
    logic [15:0] faddrc;
    logic [11:0] maddrc;
    logic [7:0]  mdatac;
    logic [12:0] wordsc;
`endif

    always #5 clk = ~clk;

    flash_loader #(
        .WORD_BITS(8), .ADDRESS_WORDS(2), .MEM_ADDR_BITS(12), .NUM_WORDS(4),
        .FLASH_START(16'h1234), .MEM_START(12'hFFE), .AUTO_START(1), .TIMEOUT_CYCLES(100)
    ) dut (
        .in_clk(clk), .in_rst(rst), .in_start(start),
        .out_busy(busy), .out_done(done), .out_error(error),
        .out_flash_enable(en), .out_flash_read(rd), .out_flash_addr(faddr),
        .in_flash_data(data), .in_flash_word_ready(ready),
`ifdef FLASH_LOADER_CHECKSUM_EN
        .in_expected_checksum(8'hAA), .out_checksum(ck),
`endif
        .out_mem_addr(maddr), .out_mem_data(mdata), .out_mem_write(wr),
        .out_words_loaded(words)
    );

    flash_loader #(
        .NUM_WORDS(0), .AUTO_START(0), .TIMEOUT_CYCLES(100)
    ) dut0 (
        .in_clk(clk), .in_rst(rst), .in_start(start0),
        .out_busy(busy0), .out_done(done0), .out_error(error0),
        .out_flash_enable(en0), .out_flash_read(rd0), .out_flash_addr(faddr0),
        .in_flash_data(8'h00), .in_flash_word_ready(1'b0),
`ifdef FLASH_LOADER_CHECKSUM_EN
        .in_expected_checksum(8'h00), .out_checksum(ck0),
`endif
        .out_mem_addr(maddr0), .out_mem_data(mdata0), .out_mem_write(wr0),
        .out_words_loaded(words0)
    );

`ifdef FLASH_LOADER_CHECKSUM_EN
    flash_loader #(
        .NUM_WORDS(2), .AUTO_START(0), .TIMEOUT_CYCLES(100)
    ) dutc (
        .in_clk(clk), .in_rst(rst), .in_start(startc),
        .out_busy(busyc), .out_done(donec), .out_error(errorc),
        .out_flash_enable(enc), .out_flash_read(rdc), .out_flash_addr(faddrc),
        .in_flash_data(datac), .in_flash_word_ready(readyc),
        .in_expected_checksum(expc), .out_checksum(ckc),
        .out_mem_addr(maddrc), .out_mem_data(mdatac), .out_mem_write(wrc),
        .out_words_loaded(wordsc)
    );
`endif

    always @(posedge clk) if (en0) seen_en0 = 1'b1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic send_word(input logic [7:0] d);
        ready = 1'b1;
        data  = d;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset;
        checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (error !== 1'b0)       begin failures++; $display("FAIL rst_error got=%b exp=0", error); end
        checks++; if (en !== 1'b0)          begin failures++; $display("FAIL rst_enable got=%b exp=0", en); end
        checks++; if (rd !== 1'b1)          begin failures++; $display("FAIL rst_read got=%b exp=1", rd); end
        checks++; if (faddr !== 16'h1234)   begin failures++; $display("FAIL rst_faddr got=%h exp=1234", faddr); end
        checks++; if (wr !== 1'b0)          begin failures++; $display("FAIL rst_write got=%b exp=0", wr); end
        checks++; if (words !== 13'd0)      begin failures++; $display("FAIL rst_words got=%0d exp=0", words); end
        checks++; if (maddr !== 12'h000)    begin failures++; $display("FAIL rst_maddr got=%h exp=000", maddr); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (en !== 1'b1)          begin failures++; $display("FAIL autostart_enable got=%b exp=1", en); end
        checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL autostart_busy got=%b exp=1", busy); end
        checks++; if (done0 !== 1'b0)       begin failures++; $display("FAIL noauto_done0 got=%b exp=0", done0); end
    endtask

    task automatic test_full_load(input string tag);
        for (int i = 0; i < 4; i++) begin
            repeat (2) @(negedge clk);
            send_word(wd[i]);
            checks++; if (wr !== 1'b1)             begin failures++; $display("FAIL %s_write%0d got=%b exp=1", tag, i, wr); end
            checks++; if (maddr !== wa[i])         begin failures++; $display("FAIL %s_addr%0d got=%h exp=%h", tag, i, maddr, wa[i]); end
            checks++; if (mdata !== wd[i])         begin failures++; $display("FAIL %s_data%0d got=%h exp=%h", tag, i, mdata, wd[i]); end
            checks++; if (words !== 13'(i + 1))    begin failures++; $display("FAIL %s_words%0d got=%0d exp=%0d", tag, i, words, i + 1); end
            checks++; if (en !== (i < 3))          begin failures++; $display("FAIL %s_enable%0d got=%b exp=%b", tag, i, en, (i < 3)); end
        end
        checks++; if (done !== 1'b1)    begin failures++; $display("FAIL %s_done got=%b exp=1", tag, done); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL %s_busy got=%b exp=0", tag, busy); end
        @(negedge clk);
        checks++; if (wr !== 1'b0)      begin failures++; $display("FAIL %s_strobe_len got=%b exp=0", tag, wr); end
    endtask

    task automatic test_trailing;
        repeat (3) @(negedge clk);
        send_word(8'h55);
        checks++; if (wr !== 1'b0)      begin failures++; $display("FAIL trail_write got=%b exp=0", wr); end
        checks++; if (words !== 13'd4)  begin failures++; $display("FAIL trail_words got=%0d exp=4", words); end
        checks++; if (mdata !== 8'h44)  begin failures++; $display("FAIL trail_data got=%h exp=44", mdata); end
        checks++; if (done !== 1'b1)    begin failures++; $display("FAIL trail_done got=%b exp=1", done); end
    endtask

    task automatic test_timeout;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL to_enter got=%b exp=1", busy); end
        checks++; if (words !== 13'd0)  begin failures++; $display("FAIL to_clear got=%0d exp=0", words); end
        repeat (99) @(negedge clk);
        checks++; if (error !== 1'b0)   begin failures++; $display("FAIL to_early got=%b exp=0", error); end
        checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL to_busy99 got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (error !== 1'b1)   begin failures++; $display("FAIL to_error got=%b exp=1", error); end
        checks++; if (en !== 1'b0)      begin failures++; $display("FAIL to_enable got=%b exp=0", en); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL to_restart got=%b exp=1", busy); end
        checks++; if (error !== 1'b0)   begin failures++; $display("FAIL to_errclr got=%b exp=0", error); end
        test_full_load("to_reload");
    endtask

    task automatic test_reset_midload;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(wd[0]);
        @(negedge clk);
        send_word(wd[1]);
        checks++; if (words !== 13'd2)  begin failures++; $display("FAIL mid_words got=%0d exp=2", words); end
        #2 rst = 1'b0;
        #1;
        checks++; if (en !== 1'b0)      begin failures++; $display("FAIL mid_enable got=%b exp=0", en); end
        checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        checks++; if (wr !== 1'b0)      begin failures++; $display("FAIL mid_write got=%b exp=0", wr); end
        checks++; if (words !== 13'd0)  begin failures++; $display("FAIL mid_wclr got=%0d exp=0", words); end
        checks++; if (maddr !== 12'h0)  begin failures++; $display("FAIL mid_maddr got=%h exp=000", maddr); end
        checks++; if (mdata !== 8'h00)  begin failures++; $display("FAIL mid_mdata got=%h exp=00", mdata); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b1)    begin failures++; $display("FAIL mid_autostart got=%b exp=1", busy); end
        test_full_load("mid_reload");
    endtask

    task automatic test_zero;
        checks++; if (done0 !== 1'b0)   begin failures++; $display("FAIL zero_idle got=%b exp=0", done0); end
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checks++; if (done0 !== 1'b1)   begin failures++; $display("FAIL zero_done got=%b exp=1", done0); end
        checks++; if (busy0 !== 1'b0)   begin failures++; $display("FAIL zero_busy got=%b exp=0", busy0); end
        checks++; if (wr0 !== 1'b0)     begin failures++; $display("FAIL zero_write got=%b exp=0", wr0); end
        checks++; if (seen_en0 !== 1'b0) begin failures++; $display("FAIL zero_enable_seen got=%b exp=0", seen_en0); end
    endtask

`ifdef FLASH_LOADER_CHECKSUM_EN
    task automatic load_two;
        startc = 1'b1;
        @(negedge clk);
        startc = 1'b0;
        readyc = 1'b1; datac = 8'h80;
        @(negedge clk);
        readyc = 1'b0;
        @(negedge clk);
        readyc = 1'b1; datac = 8'h90;
        @(negedge clk);
        readyc = 1'b0;
    endtask

    task automatic test_checksum;
        expc = 8'h10;
        load_two();
        checks++; if (wrc !== 1'b1)     begin failures++; $display("FAIL ck_write got=%b exp=1", wrc); end
        checks++; if (ckc !== 8'h10)    begin failures++; $display("FAIL ck_sum got=%h exp=10", ckc); end
        checks++; if (donec !== 1'b1)   begin failures++; $display("FAIL ck_done got=%b exp=1", donec); end
        expc = 8'h11;
        @(negedge clk);
        load_two();
        checks++; if (errorc !== 1'b1)  begin failures++; $display("FAIL ck_error got=%b exp=1", errorc); end
        checks++; if (donec !== 1'b0)   begin failures++; $display("FAIL ck_notdone got=%b exp=0", donec); end
        checks++; if (wordsc !== 13'd2) begin failures++; $display("FAIL ck_words got=%0d exp=2", wordsc); end
    endtask
`endif

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        start0 = 1'b0;
        ready  = 1'b0;
        data   = 8'h00;
`ifdef FLASH_LOADER_CHECKSUM_EN
        startc = 1'b0;
        readyc = 1'b0;
        datac  = 8'h00;
        expc   = 8'h00;
`endif
        repeat (3) @(negedge clk);
        test_reset();
        test_full_load("load");
        test_trailing();
        test_timeout();
        test_reset_midload();
        test_zero();
`ifdef FLASH_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
